fifo_buffer_multi_channel: RTL and testbench

- Single-clock FIFO holding CHANNEL_COUNT independent logical queues in one shared block RAM.
- Replaces one-queue-per-RAM instances where many low-rate streams converge into a single consumer.
- One shared input port selects the channel per word.
- One shared output port is fed by a round-robin arbiter over non-empty channels, with per-channel circular (overwrite-oldest) mode.

---
 rtl/fifo_buffer_multi_channel_pkg.sv | 27 ++
 rtl/fifo_buffer_multi_channel_ram.sv | 58 +++++
 rtl/fifo_channel_pointers.sv | 56 +++++
 rtl/fifo_buffer_multi_channel.sv | 156 +++++++++++++++
 tb/tb_fifo_buffer_multi_channel.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_buffer_multi_channel_pkg.sv
// Shared constants and width helpers for the multi-channel FIFO.
package fifo_buffer_multi_channel_pkg;

    localparam int DEFAULT_WORD_WIDTH    = 32'sd8;
    localparam int DEFAULT_CHANNEL_COUNT = 32'sd4;
    localparam int DEFAULT_DEPTH         = 32'sd16;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Occupancy needs one extra bit so a full channel (DEPTH) is representable.
    function automatic int occupancy_width(input int depth);
        return clog2(depth) + 32'sd1;
    endfunction

endpackage

// File: rtl/fifo_buffer_multi_channel_ram.sv
// Simple dual-port RAM, one write port and one registered read port on a
// single clock. Reads return the old contents on a same-address write.
module fifo_buffer_multi_channel_ram #(
    parameter int    WORD_WIDTH = 8,
    parameter int    ADDR_WIDTH = 6,
    parameter string RAMSTYLE   = ""
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WORD_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [WORD_WIDTH-1:0] read_data
);

    localparam int WORDS = 32'sd1 <<< ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] mem_word_s;
    logic [WORD_WIDTH-1:0] read_data_r;

    if (RAMSTYLE == "") begin : g_plain
        logic [WORD_WIDTH-1:0] mem_r [WORDS];

        assign mem_word_s = mem_r[read_addr];

        // Storage write port.
        always_ff @(posedge clock) begin
            if (write_enable) begin
                mem_r[write_addr] <= write_data;
            end
        end
    end else begin : g_styled
        (* ramstyle = RAMSTYLE *) logic [WORD_WIDTH-1:0] mem_r [WORDS];

        assign mem_word_s = mem_r[read_addr];

        // Storage write port.
        always_ff @(posedge clock) begin
            if (write_enable) begin
                mem_r[write_addr] <= write_data;
            end
        end
    end

    // Registered read port; holds its word when no read is issued.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            read_data_r <= '0;
        end else if (read_enable) begin
            read_data_r <= mem_word_s;
        end
    end

    assign read_data = read_data_r;

endmodule

// File: rtl/fifo_channel_pointers.sv
// Pointer bookkeeping for one logical queue: write/read pointers with wrap
// bits, empty/full/occupancy flags and the overwrite-oldest drop.
module fifo_channel_pointers
    import fifo_buffer_multi_channel_pkg::*;
#(
    parameter int   DEPTH      = DEFAULT_DEPTH,
    parameter logic CIRCULAR   = 1'b0,
    localparam int  ADDR_WIDTH = clog2(DEPTH),
    localparam int  OCC_WIDTH  = occupancy_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  insert,
    input  logic                  grant,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  empty,
    output logic                  full,
    output logic [OCC_WIDTH-1:0]  occupancy
);

    // Top bit of each pointer is its wrap bit, so a plain increment wraps
    // the address and toggles the wrap bit together.
    localparam logic [OCC_WIDTH-1:0] PTR_STEP = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [OCC_WIDTH-1:0] write_ptr_r;
    logic [OCC_WIDTH-1:0] read_ptr_r;
    logic                 drop_s;

    assign write_addr = write_ptr_r[ADDR_WIDTH-1:0];
    assign read_addr  = read_ptr_r[ADDR_WIDTH-1:0];
    assign empty      = (write_ptr_r == read_ptr_r);
    assign full       = (write_ptr_r[ADDR_WIDTH-1:0] == read_ptr_r[ADDR_WIDTH-1:0]) &&
                        (write_ptr_r[ADDR_WIDTH] != read_ptr_r[ADDR_WIDTH]);
    assign occupancy  = write_ptr_r - read_ptr_r;

    // A full circular channel that is written but not granted loses its
    // oldest word; when granted, the grant itself frees the slot.
    assign drop_s = insert && full && CIRCULAR && !grant;

    // Pointer registers: advance on insert, on grant, or on an overwrite drop.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            write_ptr_r <= '0;
            read_ptr_r  <= '0;
        end else begin
            if (insert) begin
                write_ptr_r <= write_ptr_r + PTR_STEP;
            end
            if (grant || drop_s) begin
                read_ptr_r <= read_ptr_r + PTR_STEP;
            end
        end
    end

endmodule

// File: rtl/fifo_buffer_multi_channel.sv
// Multi-channel FIFO: CHANNEL_COUNT queues share one RAM, one input port
// selects the channel per word, and a round-robin arbiter feeds one output.
module fifo_buffer_multi_channel
    import fifo_buffer_multi_channel_pkg::*;
#(
    parameter int                        WORD_WIDTH          = DEFAULT_WORD_WIDTH,
    parameter int                        CHANNEL_COUNT       = DEFAULT_CHANNEL_COUNT,
    parameter int                        DEPTH               = DEFAULT_DEPTH,
    parameter string                     RAMSTYLE            = "",
    parameter logic [CHANNEL_COUNT-1:0]  CIRCULAR_BUFFER     = '0,
    localparam int                       ADDR_WIDTH          = clog2(DEPTH),
    localparam int                       CHANNEL_INDEX_WIDTH = clog2(CHANNEL_COUNT),
    localparam int                       OCC_WIDTH           = occupancy_width(DEPTH)
) (
    input  logic                               clock,
    input  logic                               clear,
    input  logic                               input_valid,
    output logic                               input_ready,
    input  logic [CHANNEL_INDEX_WIDTH-1:0]     input_channel,
    input  logic [WORD_WIDTH-1:0]              input_data,
    output logic                               output_valid,
    input  logic                               output_ready,
    output logic [CHANNEL_INDEX_WIDTH-1:0]     output_channel,
    output logic [WORD_WIDTH-1:0]              output_data,
    output logic [CHANNEL_COUNT-1:0]           channel_empty,
    output logic [CHANNEL_COUNT-1:0]           channel_full,
    output logic [CHANNEL_COUNT*OCC_WIDTH-1:0] channel_occupancy
);

    localparam int RAM_ADDR_WIDTH = CHANNEL_INDEX_WIDTH + ADDR_WIDTH;
    localparam logic [CHANNEL_INDEX_WIDTH:0] CHANNEL_LIMIT =
        (CHANNEL_INDEX_WIDTH + 1)'(CHANNEL_COUNT);
    localparam logic [CHANNEL_INDEX_WIDTH-1:0] RESET_GRANT =
        CHANNEL_INDEX_WIDTH'(CHANNEL_COUNT - 1);

    logic [CHANNEL_COUNT-1:0]       insert_s;
    logic [CHANNEL_COUNT-1:0]       grant_vec_s;
    logic [CHANNEL_COUNT-1:0]       empty_s;
    logic [CHANNEL_COUNT-1:0]       full_s;
    logic [OCC_WIDTH-1:0]           occ_s      [CHANNEL_COUNT];
    logic [ADDR_WIDTH-1:0]          wr_addr_s  [CHANNEL_COUNT];
    logic [ADDR_WIDTH-1:0]          rd_addr_s  [CHANNEL_COUNT];
    logic                           ready_s;
    logic                           load_s;
    logic                           grant_found_s;
    logic                           grant_s;
    logic [CHANNEL_INDEX_WIDTH-1:0] grant_ch_s;
    logic [CHANNEL_INDEX_WIDTH-1:0] cand_s;
    logic                           output_valid_r;
    logic [CHANNEL_INDEX_WIDTH-1:0] output_channel_r;
    logic [CHANNEL_INDEX_WIDTH-1:0] last_grant_r;

    // Per-channel pointer state.
    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_channel
        fifo_channel_pointers #(
            .DEPTH    (DEPTH),
            .CIRCULAR (CIRCULAR_BUFFER[c])
        ) u_pointers (
            .clock      (clock),
            .clear      (clear),
            .insert     (insert_s[c]),
            .grant      (grant_vec_s[c]),
            .write_addr (wr_addr_s[c]),
            .read_addr  (rd_addr_s[c]),
            .empty      (empty_s[c]),
            .full       (full_s[c]),
            .occupancy  (occ_s[c])
        );
        assign channel_occupancy[c*OCC_WIDTH +: OCC_WIDTH] = occ_s[c];
    end

    assign channel_empty = empty_s;
    assign channel_full  = full_s;
    assign input_ready   = ready_s;

    // Input decode: ready for a valid, non-full (or circular) channel.
    always_comb begin
        ready_s  = 1'b0;
        insert_s = '0;
        if ({1'b0, input_channel} < CHANNEL_LIMIT) begin
            ready_s = !full_s[input_channel] || CIRCULAR_BUFFER[input_channel];
        end else begin
            ready_s = 1'b0;
        end
        if (input_valid && ready_s) begin
            insert_s[input_channel] = 1'b1;
        end else begin
            insert_s = '0;
        end
    end

    assign load_s = !output_valid_r || output_ready;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        grant_found_s = 1'b0;
        grant_ch_s    = '0;
        cand_s        = '0;
        for (int i = 1; i <= CHANNEL_COUNT; i++) begin
            cand_s = CHANNEL_INDEX_WIDTH'((int'(last_grant_r) + i) % CHANNEL_COUNT);
            if (!grant_found_s && !empty_s[cand_s]) begin
                grant_found_s = 1'b1;
                grant_ch_s    = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign grant_s = load_s && grant_found_s;

    // One-hot grant towards the pointer blocks.
    always_comb begin
        grant_vec_s = '0;
        if (grant_s) begin
            grant_vec_s[grant_ch_s] = 1'b1;
        end else begin
            grant_vec_s = '0;
        end
    end

    // Output handshake state and round-robin history.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            output_valid_r   <= 1'b0;
            output_channel_r <= '0;
            last_grant_r     <= RESET_GRANT;
        end else if (load_s) begin
            output_valid_r <= grant_found_s;
            if (grant_found_s) begin
                output_channel_r <= grant_ch_s;
                last_grant_r     <= grant_ch_s;
            end
        end
    end

    assign output_valid   = output_valid_r;
    assign output_channel = output_channel_r;

    // Shared storage; its registered read port is the output data register.
    fifo_buffer_multi_channel_ram #(
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_WIDTH (RAM_ADDR_WIDTH),
        .RAMSTYLE   (RAMSTYLE)
    ) u_ram (
        .clock        (clock),
        .clear        (clear),
        .write_enable (|insert_s),
        .write_addr   ({input_channel, wr_addr_s[input_channel]}),
        .write_data   (input_data),
        .read_enable  (grant_s),
        .read_addr    ({grant_ch_s, rd_addr_s[grant_ch_s]}),
        .read_data    (output_data)
    );

endmodule

// File: tb/tb_fifo_buffer_multi_channel.sv
// Directed self-checking bench for fifo_buffer_multi_channel
// (DEPTH=4, four channels, channel 1 circular).
module tb_fifo_buffer_multi_channel;

    logic        clock;
    logic        clear;
    logic        input_valid;
    logic        input_ready;
    logic [1:0]  input_channel;
    logic [7:0]  input_data;
    logic        output_valid;
    logic        output_ready;
    logic [1:0]  output_channel;
    logic [7:0]  output_data;
    logic [3:0]  channel_empty;
    logic [3:0]  channel_full;
    logic [11:0] channel_occupancy;

    int checks;
    int failures;

    logic [1:0] fair_ch [5];
    logic [7:0] fair_d  [5];
    logic [7:0] circ_d  [5];

    fifo_buffer_multi_channel #(
        .WORD_WIDTH      (8),
        .CHANNEL_COUNT   (4),
        .DEPTH           (4),
        .RAMSTYLE        (""),
        .CIRCULAR_BUFFER (4'b0010)
    ) dut (
        .clock             (clock),
        .clear             (clear),
        .input_valid       (input_valid),
        .input_ready       (input_ready),
        .input_channel     (input_channel),
        .input_data        (input_data),
        .output_valid      (output_valid),
        .output_ready      (output_ready),
        .output_channel    (output_channel),
        .output_data       (output_data),
        .channel_empty     (channel_empty),
        .channel_full      (channel_full),
        .channel_occupancy (channel_occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] occ(input int ch);
        return channel_occupancy[ch*3 +: 3];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one word for one cycle, checking input_ready before the edge.
    task automatic push(input logic [1:0] ch, input logic [7:0] d, input logic exp_ready);
        input_valid   = 1'b1;
        input_channel = ch;
        input_data    = d;
        #1;
        check_value("push_ready", {31'd0, input_ready}, {31'd0, exp_ready});
        tick();
        input_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        fair_ch = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
        fair_d  = '{8'd1, 8'd11, 8'd31, 8'd2, 8'd12};
        circ_d  = '{8'h10, 8'h13, 8'h14, 8'h15, 8'h16};
        clear = 1'b1;
        input_valid = 1'b0;
        input_channel = 2'd0;
        input_data = 8'd0;
        output_ready = 1'b0;

        // Reset state
        #12;
        check_value("rst_valid", {31'd0, output_valid}, 32'd0);
        check_value("rst_data", {24'd0, output_data}, 32'd0);
        check_value("rst_chan", {30'd0, output_channel}, 32'd0);
        check_value("rst_empty", {28'd0, channel_empty}, 32'hF);
        check_value("rst_full", {28'd0, channel_full}, 32'h0);
        check_value("rst_occ", {20'd0, channel_occupancy}, 32'h0);
        check_value("rst_ready", {31'd0, input_ready}, 32'd1);
        clear = 1'b0;
        tick();

        // Latency: write edge, then read edge
        push(2'd3, 8'h55, 1'b1);
        check_value("lat_valid_early", {31'd0, output_valid}, 32'd0);
        check_value("lat_occ3", {29'd0, occ(3)}, 32'd1);
        tick();
        check_value("lat_valid", {31'd0, output_valid}, 32'd1);
        check_value("lat_data", {24'd0, output_data}, 32'h55);
        check_value("lat_chan", {30'd0, output_channel}, 32'd3);
        check_value("lat_empty", {28'd0, channel_empty}, 32'hF);
        output_ready = 1'b1;
        tick();
        check_value("lat_drained", {31'd0, output_valid}, 32'd0);
        output_ready = 1'b0;

        // Fill and drain channel 2
        for (int i = 0; i < 4; i++) push(2'd2, 8'hA0 + 8'(i), 1'b1);
        check_value("fill_occ3", {29'd0, occ(2)}, 32'd3);
        check_value("fill_notfull", {28'd0, channel_full}, 32'h0);
        check_value("fill_head", {24'd0, output_data}, 32'hA0);
        check_value("fill_head_ch", {30'd0, output_channel}, 32'd2);
        push(2'd2, 8'hA4, 1'b1);
        check_value("fill_occ4", {29'd0, occ(2)}, 32'd4);
        check_value("fill_full", {28'd0, channel_full}, 32'h4);
        push(2'd2, 8'hA5, 1'b0);
        check_value("refuse_occ", {29'd0, occ(2)}, 32'd4);
        input_channel = 2'd0;
        #1;
        check_value("other_ready", {31'd0, input_ready}, 32'd1);
        output_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_value("drain_valid", {31'd0, output_valid}, 32'd1);
            check_value("drain_data", {24'd0, output_data}, 32'hA0 + i);
            check_value("drain_chan", {30'd0, output_channel}, 32'd2);
            tick();
        end
        check_value("drain_end", {31'd0, output_valid}, 32'd0);
        check_value("drain_occ", {29'd0, occ(2)}, 32'd0);
        output_ready = 1'b0;

        // Fairness
        push(2'd0, 8'd1, 1'b1);
        push(2'd0, 8'd2, 1'b1);
        push(2'd1, 8'd11, 1'b1);
        push(2'd1, 8'd12, 1'b1);
        push(2'd3, 8'd31, 1'b1);
        output_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_value("fair_valid", {31'd0, output_valid}, 32'd1);
            check_value("fair_chan", {30'd0, output_channel}, {30'd0, fair_ch[i]});
            check_value("fair_data", {24'd0, output_data}, {24'd0, fair_d[i]});
            tick();
        end
        check_value("fair_end", {31'd0, output_valid}, 32'd0);
        output_ready = 1'b0;

        // Circular overflow on channel 1
        push(2'd1, 8'h10, 1'b1);
        for (int i = 1; i < 7; i++) push(2'd1, 8'h10 + 8'(i), 1'b1);
        check_value("circ_occ", {29'd0, occ(1)}, 32'd4);
        check_value("circ_full", {28'd0, channel_full}, 32'h2);
        output_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_value("circ_valid", {31'd0, output_valid}, 32'd1);
            check_value("circ_data", {24'd0, output_data}, {24'd0, circ_d[i]});
            check_value("circ_chan", {30'd0, output_channel}, 32'd1);
            tick();
        end
        check_value("circ_end", {31'd0, output_valid}, 32'd0);
        output_ready = 1'b0;

        // Simultaneous insert and grant on channel 0
        push(2'd0, 8'h21, 1'b1);
        push(2'd0, 8'h22, 1'b1);
        push(2'd0, 8'h23, 1'b1);
        check_value("sim_pre_occ", {29'd0, occ(0)}, 32'd2);
        output_ready = 1'b1;
        push(2'd0, 8'h24, 1'b1);
        check_value("sim_occ", {29'd0, occ(0)}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            check_value("sim_valid", {31'd0, output_valid}, 32'd1);
            check_value("sim_data", {24'd0, output_data}, 32'h22 + i);
            tick();
        end
        check_value("sim_end", {31'd0, output_valid}, 32'd0);
        output_ready = 1'b0;

        // Reset mid-operation
        push(2'd0, 8'h41, 1'b1);
        push(2'd1, 8'h51, 1'b1);
        push(2'd2, 8'h61, 1'b1);
        check_value("mid_pre_valid", {31'd0, output_valid}, 32'd1);
        #2;
        clear = 1'b1;
        #1;
        check_value("mid_valid", {31'd0, output_valid}, 32'd0);
        check_value("mid_empty", {28'd0, channel_empty}, 32'hF);
        check_value("mid_occ", {20'd0, channel_occupancy}, 32'h0);
        check_value("mid_ready", {31'd0, input_ready}, 32'd1);
        #2;
        clear = 1'b0;
        push(2'd3, 8'h77, 1'b1);
        check_value("post_valid_early", {31'd0, output_valid}, 32'd0);
        tick();
        check_value("post_valid", {31'd0, output_valid}, 32'd1);
        check_value("post_chan", {30'd0, output_channel}, 32'd3);
        check_value("post_data", {24'd0, output_data}, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
